// File: rtl/request_encoder_8_to_3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : request_encoder_8_to_3
// Purpose  : Latches an 8-bit request vector and emits one 3-bit index per
//            accepted handshake, in priority order.
// Revision : 1.0 - initial release
// ============================================================================
module request_encoder_8_to_3 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req_in,
    input  logic       load,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       busy,
    output logic       done,
    output logic       none,
    output logic [3:0] count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pend;
    logic [3:0] r_count;
    logic       r_done;
    logic       r_none;

    logic [2:0] w_code;
    logic [7:0] w_pend_next;

    // Priority encoder over the pending set; pend is all-zero in IDLE, so code reads 0 there.
    generate
        if (MSB_FIRST) begin : g_msb_first
            always_comb begin
                w_code = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (r_pend[i]) w_code = 3'(i);
                end
            end
        end else begin : g_lsb_first
            always_comb begin
                w_code = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (r_pend[i]) w_code = 3'(i);
                end
            end
        end
    endgenerate

    assign w_pend_next = r_pend & ~(8'd1 << w_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pend  <= 8'd0;
            r_count <= 4'd0;
            r_done  <= 1'b0;
            r_none  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_none <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_count <= 4'd0;
                        if (req_in != 8'd0) begin
                            r_pend  <= req_in;
                            r_state <= ST_SCAN;
                        end else begin
                            r_none <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    // Loads are ignored here, including on the final accept.
                    if (code_ready) begin
                        r_pend  <= w_pend_next;
                        r_count <= r_count + 4'd1;
                        if (w_pend_next == 8'd0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign code       = w_code;
    assign code_valid = (r_state == ST_SCAN);
    assign busy       = (r_state == ST_SCAN);
    assign done       = r_done;
    assign none       = r_none;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_request_encoder_8_to_3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_request_encoder_8_to_3
// Purpose  : Drives LSB-first and MSB-first encoders side by side against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_encoder_8_to_3;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       code_ready;
    logic [7:0] req_in;

    logic [2:0] code_l, code_m;
    logic       cv_l, cv_m, busy_l, busy_m, done_l, done_m, none_l, none_m;
    logic [3:0] cnt_l, cnt_m;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each load becomes a queue of indices in scan order.
    int         q_l[$];
    int         q_m[$];
    int         m_count[2];
    logic       m_done[2];
    logic       m_none[2];
    logic [7:0] loaded[2];
    logic [7:0] acc[2];

    always #5 clk = ~clk;

    request_encoder_8_to_3 #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .req_in(req_in), .load(load),
        .code(code_l), .code_valid(cv_l), .code_ready(code_ready),
        .busy(busy_l), .done(done_l), .none(none_l), .count(cnt_l)
    );

    request_encoder_8_to_3 #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .req_in(req_in), .load(load),
        .code(code_m), .code_valid(cv_m), .code_ready(code_ready),
        .busy(busy_m), .done(done_m), .none(none_m), .count(cnt_m)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_l.delete();
        q_m.delete();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0;
            m_done[k]  = 1'b0;
            m_none[k]  = 1'b0;
            acc[k]     = 8'd0;
            loaded[k]  = 8'd0;
        end
    endtask

    task automatic model_step(input logic ld, input logic [7:0] rq, input logic rdy);
        m_done[0] = 1'b0; m_none[0] = 1'b0;
        m_done[1] = 1'b0; m_none[1] = 1'b0;
        if (q_l.size() == 0) begin
            if (ld) begin
                m_count[0] = 0;
                if (rq == 8'd0) m_none[0] = 1'b1;
                else begin
                    loaded[0] = rq; acc[0] = 8'd0;
                    for (int i = 0; i < 8; i++) if (rq[i]) q_l.push_back(i);
                end
            end
        end else if (rdy) begin
            void'(q_l.pop_front());
            m_count[0]++;
            if (q_l.size() == 0) m_done[0] = 1'b1;
        end
        if (q_m.size() == 0) begin
            if (ld) begin
                m_count[1] = 0;
                if (rq == 8'd0) m_none[1] = 1'b1;
                else begin
                    loaded[1] = rq; acc[1] = 8'd0;
                    for (int i = 0; i < 8; i++) if (rq[i]) q_m.push_front(i);
                end
            end
        end else if (rdy) begin
            void'(q_m.pop_front());
            m_count[1]++;
            if (q_m.size() == 0) m_done[1] = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("lsb_valid", 32'(cv_l),   32'(q_l.size() != 0));
        check("lsb_busy",  32'(busy_l), 32'(q_l.size() != 0));
        check("lsb_code",  32'(code_l), (q_l.size() != 0) ? q_l[0] : 0);
        check("lsb_count", 32'(cnt_l),  m_count[0]);
        check("lsb_done",  32'(done_l), 32'(m_done[0]));
        check("lsb_none",  32'(none_l), 32'(m_none[0]));
        check("msb_valid", 32'(cv_m),   32'(q_m.size() != 0));
        check("msb_busy",  32'(busy_m), 32'(q_m.size() != 0));
        check("msb_code",  32'(code_m), (q_m.size() != 0) ? q_m[0] : 0);
        check("msb_count", 32'(cnt_m),  m_count[1]);
        check("msb_done",  32'(done_m), 32'(m_done[1]));
        check("msb_none",  32'(none_m), 32'(m_none[1]));
        if (m_done[0]) check("lsb_roundtrip", 32'(acc[0]), 32'(loaded[0]));
        if (m_done[1]) check("msb_roundtrip", 32'(acc[1]), 32'(loaded[1]));
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input logic ld, input logic [7:0] rq, input logic rdy);
        load       = ld;
        req_in     = rq;
        code_ready = rdy;
        #1;
        if (cv_l && rdy) acc[0] = acc[0] | (8'd1 << code_l);
        if (cv_m && rdy) acc[1] = acc[1] | (8'd1 << code_m);
        @(posedge clk);
        model_step(ld, rq, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        load = 1'b0; req_in = 8'd0; code_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_clear();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; req_in = 8'd0; code_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Reset in the middle of a scan, then a fresh single-bit load.
        cycle(1'b1, 8'hFF, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        async_reset();
        cycle(1'b1, 8'h01, 1'b1);
        check("post_reset_code_l", 32'(code_l), 0);
        check("post_reset_code_m", 32'(code_m), 0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Mixed vector, ready held high.
        cycle(1'b1, 8'hA6, 1'b1);
        check("a6_first_l", 32'(code_l), 1);
        check("a6_first_m", 32'(code_m), 7);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        check("a6_count", 32'(cnt_l), 4);
        check("a6_done", 32'(done_l), 1);
        cycle(1'b0, 8'h00, 1'b1);

        // Backpressure.
        cycle(1'b1, 8'h81, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);

        // Zero load, then loads while busy.
        cycle(1'b1, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h10, 1'b1);
        cycle(1'b1, 8'h10, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Full vector, reload on the done cycle.
        cycle(1'b1, 8'hFF, 1'b1);
        repeat (8) cycle(1'b0, 8'h00, 1'b1);
        check("ff_count", 32'(cnt_l), 8);
        cycle(1'b1, 8'h40, 1'b1);
        check("reload_code_l", 32'(code_l), 6);
        check("reload_code_m", 32'(code_m), 6);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // Random traffic with one more asynchronous reset part-way through.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) async_reset();
            cycle($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/request_encoder_8_to_3.md
Name: request_encoder_8_to_3

Overview:
- Sequential 8-to-3 encoder; the inverse of the 3-to-8 one-hot decoder.
- Latches an 8-bit request vector and emits the 3-bit index of every set bit, one index per handshake, in priority order.
- Sits between request sources and anything that consumes binary select codes, for example a decoder that regenerates the one-hot strobes.

Parameters:
- MSB_FIRST, 0, scan priority: 0 = bit 0 highest priority (lowest index first); 1 = bit 7 first.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active-high
- req_in  input  8  request vector, sampled on load
- load  input  1  capture req_in; honoured only when busy=0
- code  output  3  index of the current highest-priority pending bit
- code_valid  output  1  code is valid
- code_ready  input  1  consumer accepts code this cycle
- busy  output  1  encoder holds pending requests
- done  output  1  one-cycle pulse after the last code is accepted
- none  output  1  one-cycle pulse when load captured an all-zero vector
- count  output  4  number of codes accepted since the last load (0..8)

Behaviour:
- Reset (asynchronous, active-high, immediate, including mid-scan):
  - state=IDLE, pend=0, count=0.
  - code=0, code_valid=0, busy=0, done=0, none=0.
- State registers: 1-bit state (IDLE, SCAN), 8-bit pend, 4-bit count, registered done/none pulses.
- code and code_valid are derived only from registers. There is no combinational path from req_in, load or code_ready to any output.
- IDLE:
  - busy=0, code_valid=0, code=0.
  - load=1 with req_in!=0: next cycle pend=req_in, count=0, state=SCAN.
  - load=1 with req_in==0: next cycle none=1 for exactly one cycle, count=0, stay IDLE.
  - load=0: hold.
- SCAN:
  - busy=1, code_valid=1.
  - code = index of the lowest set bit of pend (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
  - code holds stable while code_ready=0.
  - Accept = code_valid & code_ready at a rising edge. On accept:
    - clear pend[code];
    - count increments by 1;
    - if pend becomes 0: state=IDLE and done=1 for the next cycle only.
  - No accept: pend, count and code unchanged.
- load while busy=1 is ignored; pend is not modified.
- A load in the same cycle as the final accept is also ignored, because busy=1 in that cycle.
- load is accepted again from the first cycle with busy=0, which is the done cycle.
- Latency:
  - load edge to first code_valid: 1 cycle.
  - Back-to-back accepts: one code per cycle.
  - A vector with N set bits needs N accepted cycles.
- Output pulses:
  - done and none never assert simultaneously.
  - Each is exactly 1 cycle wide and occurs only in IDLE.
- count holds its final value in IDLE until the next load, or until reset.
- Round trip: feeding code into the 3-to-8 decoder (en=1) and ORing its outputs over the scan must reproduce the loaded vector.

Test Plan:
- Reset mid-scan: load 8'hFF, accept 3 codes, assert reset asynchronously between edges -> outputs clear immediately (busy=0, code_valid=0, count=0); the next load 8'h01 gives code=0.
- LSB-first scan: MSB_FIRST=0, load 8'b1010_0110, code_ready=1 -> codes 1,2,5,7 on consecutive cycles; done pulses one cycle after code 7; count=4.
- MSB-first scan: MSB_FIRST=1, load 8'b1010_0110 -> codes 7,5,2,1; count=4.
- Backpressure: load 8'h81 with code_ready=0 for 5 cycles -> code=0 held, code_valid=1, count=0. Then code_ready=1 -> codes 0,7, then done.
- Zero and busy loads:
  - load 8'h00 -> none=1 for one cycle, busy stays 0, code_valid stays 0.
  - load 8'h10 during an active 8'h03 scan -> ignored; only codes 0,1 emitted.
- Full vector and immediate reload: load 8'hFF -> codes 0..7 in 8 cycles, count=8. load 8'h40 on the done cycle -> accepted; code=6 on the next cycle.
